// File: rtl/fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : fc_layer_engine
// Brief    : Time-multiplexed fully-connected layer with a single signed MAC,
//            external sync weight/bias memories, optional ReLU, saturation and
//            running argmax. Ready/valid handshake on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module fc_layer_engine #(
    parameter int N_IN      = 784,
    parameter int N_OUT     = 16,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 48,
    parameter int RELU_EN   = 1,
    localparam int WA_W = ($clog2(N_IN*N_OUT) > 0) ? $clog2(N_IN*N_OUT) : 1,
    localparam int OA_W = ($clog2(N_OUT) > 0) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic signed [DATA_W-1:0] input_vector [0:N_IN-1],
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic        [WA_W-1:0]   w_addr,
    input  logic signed [DATA_W-1:0] w_rdata,
    output logic        [OA_W-1:0]   b_addr,
    input  logic signed [DATA_W-1:0] b_rdata,
    output logic signed [DATA_W-1:0] output_vector [0:N_OUT-1],
    output logic        [OA_W-1:0]   out_argmax,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int                      I_W       = ($clog2(N_IN) > 0) ? $clog2(N_IN) : 1;
    localparam logic [I_W-1:0]          c_I_LAST  = I_W'(N_IN - 1);
    localparam logic [OA_W-1:0]         c_O_LAST  = OA_W'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAC   = 3'd1,
        S_DRAIN = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_W-1:0]   r_xbuf [0:N_IN-1];
    logic signed [DATA_W-1:0]   r_res  [0:N_OUT-1];
    logic        [OA_W-1:0]     r_o;
    logic        [I_W-1:0]      r_i;
    logic        [I_W-1:0]      r_i_d;
    logic                       r_mac_vld;
    logic                       r_bias_vld;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [DATA_W-1:0]   r_bias;
    logic signed [DATA_W-1:0]   r_max;
    logic        [OA_W-1:0]     r_idx;

    logic                       w_accept;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_shift;
    logic signed [ACC_W-1:0]    w_relu;
    logic signed [DATA_W-1:0]   w_s;
    logic                       w_upd;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_addr    = (r_state == S_MAC) ? WA_W'(int'(r_o) * N_IN + int'(r_i)) : '0;
    assign b_addr    = r_o;

    // Product pairs the weight returned this cycle with the index issued last cycle
    assign w_prod     = r_xbuf[r_i_d] * w_rdata;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias} <<< FRAC_BITS;
    assign w_sum      = r_acc + w_bias_ext;
    assign w_shift    = w_sum >>> FRAC_BITS;
    assign w_relu     = ((RELU_EN != 0) && (w_shift < 0)) ? '0 : w_shift;

    always_comb begin
        w_s = w_relu[DATA_W-1:0];
        if (w_relu > c_SAT_MAX) begin
            w_s = c_SAT_MAX[DATA_W-1:0];
        end else if (w_relu < c_SAT_MIN) begin
            w_s = c_SAT_MIN[DATA_W-1:0];
        end
    end

    // Strict compare so ties keep the lowest index
    assign w_upd = (r_o == '0) || (w_s > r_max);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)        w_state_nxt = S_MAC;
            S_MAC:   if (r_i == c_I_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN:                      w_state_nxt = S_POST;
            S_POST:  w_state_nxt = (r_o == c_O_LAST) ? S_DONE : S_MAC;
            S_DONE:  if (out_ready)       w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xbuf <= input_vector;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_o        <= '0;
            r_i        <= '0;
            r_i_d      <= '0;
            r_mac_vld  <= 1'b0;
            r_bias_vld <= 1'b0;
            r_acc      <= '0;
            r_bias     <= '0;
            r_max      <= '0;
            r_idx      <= '0;
            out_argmax <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                r_res[k]         <= '0;
                output_vector[k] <= '0;
            end
        end else begin
            r_mac_vld  <= (r_state == S_MAC);
            r_bias_vld <= (r_state == S_MAC) && (r_i == '0);
            r_i_d      <= r_i;
            if (r_mac_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end
            if (r_bias_vld) begin
                r_bias <= b_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_o   <= '0;
                        r_i   <= '0;
                        r_acc <= '0;
                    end
                end
                S_MAC: begin
                    if (r_i != c_I_LAST) begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_POST: begin
                    r_res[r_o] <= w_s;
                    if (w_upd) begin
                        r_max <= w_s;
                        r_idx <= r_o;
                    end
                    if (r_o != c_O_LAST) begin
                        r_o   <= r_o + 1'b1;
                        r_i   <= '0;
                        r_acc <= '0;
                    end else begin
                        // Last neuron's result is still in flight to r_res, forward it
                        for (int k = 0; k < N_OUT; k++) begin
                            output_vector[k] <= (OA_W'(k) == r_o) ? w_s : r_res[k];
                        end
                        out_argmax <= w_upd ? r_o : r_idx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_layer_engine
// Brief    : Self-checking bench for fc_layer_engine (ReLU and linear instances)
//            against an arithmetic reference model of the layer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_layer_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int NW    = N_IN * N_OUT;
    localparam int WA_W  = $clog2(NW);
    localparam int OA_W  = $clog2(N_OUT);
    localparam int LAT   = N_OUT * (N_IN + 2);

    logic clk       = 1'b0;
    logic rstN      = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic signed [15:0] in_vec [0:N_IN-1];

    logic              in_ready_r, in_ready_l, out_valid_r, out_valid_l;
    logic [WA_W-1:0]   w_addr_r, w_addr_l;
    logic [OA_W-1:0]   b_addr_r, b_addr_l, am_r, am_l;
    logic signed [15:0] w_rdata_r, w_rdata_l, b_rdata_r, b_rdata_l;
    logic signed [15:0] ov_r [0:N_OUT-1];
    logic signed [15:0] ov_l [0:N_OUT-1];

    logic signed [15:0] wmem  [0:NW-1];
    logic signed [15:0] bmem  [0:N_OUT-1];
    logic signed [15:0] x_ref [0:N_IN-1];
    logic signed [15:0] exp_r [0:N_OUT-1];
    logic signed [15:0] exp_l [0:N_OUT-1];
    int exp_am_r, exp_am_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_rdata_r <= (w_addr_r < WA_W'(NW)) ? wmem[w_addr_r] : 16'sd0;
        w_rdata_l <= (w_addr_l < WA_W'(NW)) ? wmem[w_addr_l] : 16'sd0;
        b_rdata_r <= (b_addr_r < OA_W'(N_OUT)) ? bmem[b_addr_r] : 16'sd0;
        b_rdata_l <= (b_addr_l < OA_W'(N_OUT)) ? bmem[b_addr_l] : 16'sd0;
    end

    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(16), .FRAC_BITS(8),
                      .ACC_W(48), .RELU_EN(1)) u_dut_relu (
        .clk(clk), .rstN(rstN), .input_vector(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_r), .w_addr(w_addr_r), .w_rdata(w_rdata_r),
        .b_addr(b_addr_r), .b_rdata(b_rdata_r), .output_vector(ov_r),
        .out_argmax(am_r), .out_valid(out_valid_r), .out_ready(out_ready));

    fc_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(16), .FRAC_BITS(8),
                      .ACC_W(48), .RELU_EN(0)) u_dut_lin (
        .clk(clk), .rstN(rstN), .input_vector(in_vec), .in_valid(in_valid),
        .in_ready(in_ready_l), .w_addr(w_addr_l), .w_rdata(w_rdata_l),
        .b_addr(b_addr_l), .b_rdata(b_rdata_l), .output_vector(ov_l),
        .out_argmax(am_l), .out_valid(out_valid_l), .out_ready(out_ready));

    function automatic logic signed [15:0] rnd(int lo, int hi);
        return 16'(int'($urandom_range(hi - lo)) + lo);
    endfunction

    function automatic longint clamp16(longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: exact dot product, floor divide by 2^8, then ReLU / clamp / argmax
    task automatic compute_model();
        longint acc, s, sr, sl, best_r, best_l;
        best_r = 0;
        best_l = 0;
        for (int o = 0; o < N_OUT; o++) begin
            acc = longint'(bmem[o]) * 256;
            for (int i = 0; i < N_IN; i++)
                acc += longint'(x_ref[i]) * longint'(wmem[o*N_IN+i]);
            s = acc / 256;
            if ((acc % 256) != 0 && acc < 0) s = s - 1;
            sl = clamp16(s);
            sr = clamp16((s < 0) ? 0 : s);
            exp_l[o] = 16'(sl);
            exp_r[o] = 16'(sr);
            if (o == 0 || sr > best_r) begin best_r = sr; exp_am_r = o; end
            if (o == 0 || sl > best_l) begin best_l = sl; exp_am_l = o; end
        end
    endtask

    task automatic start_job();
        @(posedge clk); #1;
        for (int i = 0; i < N_IN; i++) x_ref[i] = in_vec[i];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) in_vec[i] = rnd(-32768, 32767);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid_r !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_job();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (in_ready_r !== 1'b1 || out_valid_r !== 1'b0 || am_r !== '0 || w_addr_r !== '0 ||
            b_addr_r !== '0 || ov_r[0] !== 16'sd0 || ov_r[1] !== 16'sd0 || ov_r[2] !== 16'sd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b argmax=%0d w_addr=%0d ov0=%0d required 1 0 0 0 0",
                     in_ready_r, out_valid_r, am_r, w_addr_r, ov_r[0]);
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        for (int i = 0; i < N_IN; i++) begin in_vec[i] = 16'sd256; wmem[i] = 16'sd128; end
        for (int k = N_IN; k < NW; k++) wmem[k] = rnd(-256, 255);
        bmem[0] = 16'sd64; bmem[1] = rnd(-500, 500); bmem[2] = rnd(-500, 500);
        start_job();
        compute_model();
        wait_valid(lat);
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
        checks++;
        if (ov_r[0] !== 16'sd576 || ov_l[0] !== 16'sd576) begin
            errors++; $display("FAIL basic_out0: relu %0d lin %0d required 576", ov_r[0], ov_l[0]);
        end
        checks++;
        if (ov_l[1] !== exp_l[1] || ov_l[2] !== exp_l[2] || am_l !== OA_W'(exp_am_l)) begin
            errors++; $display("FAIL basic_rest: ov1 %0d ov2 %0d am %0d required %0d %0d %0d",
                               ov_l[1], ov_l[2], am_l, exp_l[1], exp_l[2], exp_am_l);
        end
        finish_job();
        checks++;
        if (in_ready_r !== 1'b1 || out_valid_r !== 1'b0) begin
            errors++; $display("FAIL basic_handshake: in_ready %b out_valid %b required 1 0", in_ready_r, out_valid_r);
        end
    endtask

    task automatic test_relu();
        int lat;
        for (int i = 0; i < N_IN; i++) begin in_vec[i] = 16'sd256; wmem[N_IN+i] = -16'sd96; end
        bmem[1] = 16'sd0;
        start_job();
        wait_valid(lat);
        checks++;
        if (ov_r[1] !== 16'sd0) begin errors++; $display("FAIL relu_on: got %0d required 0", ov_r[1]); end
        checks++;
        if (ov_l[1] !== -16'sd384) begin errors++; $display("FAIL relu_off: got %0d required -384", ov_l[1]); end
        finish_job();
    endtask

    task automatic test_saturation();
        int lat;
        for (int i = 0; i < N_IN; i++) begin
            in_vec[i] = 16'sd32512; wmem[i] = 16'sd32512; wmem[N_IN+i] = -16'sd32512; wmem[2*N_IN+i] = 16'sd0;
        end
        for (int o = 0; o < N_OUT; o++) bmem[o] = 16'sd0;
        start_job();
        wait_valid(lat);
        checks++;
        if (ov_r[0] !== 16'sd32767 || ov_l[0] !== 16'sd32767) begin
            errors++; $display("FAIL sat_pos: relu %0d lin %0d required 32767", ov_r[0], ov_l[0]);
        end
        checks++;
        if (ov_l[1] !== -16'sd32768 || ov_r[1] !== 16'sd0) begin
            errors++; $display("FAIL sat_neg: lin %0d relu %0d required -32768 0", ov_l[1], ov_r[1]);
        end
        finish_job();
    endtask

    task automatic test_argmax();
        int lat;
        for (int k = 0; k < NW; k++) wmem[k] = 16'sd0;
        for (int i = 0; i < N_IN; i++) in_vec[i] = rnd(-32768, 32767);
        bmem[0] = 16'sd300; bmem[1] = 16'sd700; bmem[2] = 16'sd700;
        start_job();
        wait_valid(lat);
        checks++;
        if (am_r !== 2'd1 || am_l !== 2'd1 || ov_r[0] !== 16'sd300 || ov_r[2] !== 16'sd700) begin
            errors++; $display("FAIL argmax_tie: relu %0d lin %0d ov0 %0d ov2 %0d required 1 1 300 700",
                               am_r, am_l, ov_r[0], ov_r[2]);
        end
        finish_job();
        for (int o = 0; o < N_OUT; o++) bmem[o] = 16'sd500;
        start_job();
        wait_valid(lat);
        checks++;
        if (am_r !== 2'd0 || am_l !== 2'd0) begin
            errors++; $display("FAIL argmax_equal: relu %0d lin %0d required 0", am_r, am_l);
        end
        finish_job();
    endtask

    task automatic test_random();
        int lat;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < N_IN; i++)
                in_vec[i] = (j % 2 == 0) ? rnd(-1024, 1024) : rnd(-32768, 32767);
            for (int k = 0; k < NW; k++)
                wmem[k] = (j % 2 == 0) ? rnd(-512, 512) : rnd(-32768, 32767);
            for (int o = 0; o < N_OUT; o++) bmem[o] = rnd(-2000, 2000);
            out_ready = (j == 1);
            start_job();
            compute_model();
            wait_valid(lat);
            checks++;
            if (lat != LAT) begin errors++; $display("FAIL rand%0d_latency: got %0d required %0d", j, lat, LAT); end
            for (int o = 0; o < N_OUT; o++) begin
                checks++;
                if (ov_r[o] !== exp_r[o] || ov_l[o] !== exp_l[o]) begin
                    errors++; $display("FAIL rand%0d_out%0d: relu %0d lin %0d required %0d %0d",
                                       j, o, ov_r[o], ov_l[o], exp_r[o], exp_l[o]);
                end
            end
            checks++;
            if (am_r !== OA_W'(exp_am_r) || am_l !== OA_W'(exp_am_l)) begin
                errors++; $display("FAIL rand%0d_argmax: relu %0d lin %0d required %0d %0d",
                                   j, am_r, am_l, exp_am_r, exp_am_l);
            end
            finish_job();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic ok;
        for (int i = 0; i < N_IN; i++) in_vec[i] = rnd(1, 2000);
        for (int k = 0; k < NW; k++) wmem[k] = rnd(1, 511);
        for (int o = 0; o < N_OUT; o++) bmem[o] = rnd(1, 500);
        start_job();
        compute_model();
        checks++;
        if (in_ready_r !== 1'b0) begin errors++; $display("FAIL bp_busy_ready: got %b required 0", in_ready_r); end
        wait_valid(lat);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_vec[0] = rnd(-32768, 32767);
            @(posedge clk); #1;
            ok = (out_valid_r === 1'b1) && (in_ready_r === 1'b0);
            for (int o = 0; o < N_OUT; o++) ok = ok && (ov_r[o] === exp_r[o]);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL bp_hold%0d: out_valid %b in_ready %b ov0 %0d required 1 0 %0d",
                                   c, out_valid_r, in_ready_r, ov_r[0], exp_r[0]);
            end
        end
        in_valid = 1'b0;
        finish_job();
        ok = (in_ready_r === 1'b1) && (out_valid_r === 1'b0);
        for (int o = 0; o < N_OUT; o++) ok = ok && (ov_r[o] === exp_r[o]) && (ov_l[o] === exp_l[o]);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_release: in_ready %b out_valid %b ov0 %0d required 1 0 %0d",
                               in_ready_r, out_valid_r, ov_r[0], exp_r[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        start_job();
        repeat (5) @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checks++;
        if (in_ready_r !== 1'b1 || out_valid_r !== 1'b0 || am_r !== '0 || w_addr_r !== '0 ||
            ov_r[0] !== 16'sd0 || ov_r[1] !== 16'sd0 || ov_r[2] !== 16'sd0 || ov_l[0] !== 16'sd0) begin
            errors++; $display("FAIL reset_async: in_ready %b out_valid %b ov0 %0d ov1 %0d required 1 0 0 0",
                               in_ready_r, out_valid_r, ov_r[0], ov_r[1]);
        end
        @(negedge clk);
        rstN = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid_r !== 1'b0 || out_valid_l !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_abort: out_valid seen 1 required 0"); end
        for (int i = 0; i < N_IN; i++) in_vec[i] = rnd(-3000, 3000);
        start_job();
        compute_model();
        wait_valid(lat);
        checks++;
        if (lat != LAT || ov_l[0] !== exp_l[0] || ov_l[2] !== exp_l[2]) begin
            errors++; $display("FAIL reset_recover: lat %0d ov0 %0d ov2 %0d required %0d %0d %0d",
                               lat, ov_l[0], ov_l[2], LAT, exp_l[0], exp_l[2]);
        end
        finish_job();
    endtask

    initial begin
        for (int k = 0; k < NW; k++) wmem[k] = 16'sd0;
        for (int o = 0; o < N_OUT; o++) bmem[o] = 16'sd0;
        for (int i = 0; i < N_IN; i++) in_vec[i] = 16'sd0;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_argmax();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
